// File: rtl/cb_dbuf_cfg_mux.sv
// Vertical connection block with double-buffered routing-mux selects.
// Optional readback of shadow selects is enabled by defining CFG_READBACK_EN.
module cb_dbuf_cfg_mux #(
    parameter int CHAN_WIDTH = 18,
    parameter int NUM_IPIN   = 5,
    parameter int MUX_SIZE   = 6,
    parameter int PIN_OFFSET = 2,
    parameter int TAP_STRIDE = 3,
    parameter int SEL_W      = $clog2(MUX_SIZE),
    parameter int ADDR_W     = (NUM_IPIN > 2) ? $clog2(NUM_IPIN) : 1
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic [CHAN_WIDTH-1:0] chany_in,
    output logic [CHAN_WIDTH-1:0] chany_out,
    output logic [NUM_IPIN-1:0]   grid_pin,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [SEL_W-1:0]      cfg_wdata,
    input  logic                  cfg_commit,
    output logic                  cfg_pending,
    output logic                  cfg_err,
    input  logic                  cfg_err_clr
`ifdef CFG_READBACK_EN
    ,
    output logic [SEL_W-1:0]      cfg_rdata,
    output logic                  cfg_rvalid
`endif
);

    localparam int SEL_N = 1 << SEL_W;
    localparam logic [ADDR_W:0] NUM_IPIN_L = NUM_IPIN[ADDR_W:0];
    localparam logic [SEL_W:0]  MUX_SIZE_L = MUX_SIZE[SEL_W:0];

    typedef enum logic [1:0] {IDLE, COMMIT, RD_RSP} state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      shadow_q [NUM_IPIN];
    logic [SEL_W-1:0]      shadow_d [NUM_IPIN];
    logic [SEL_W-1:0]      active_q [NUM_IPIN];
    logic [SEL_W-1:0]      active_d [NUM_IPIN];
    logic [NUM_IPIN-1:0]   dirty_q, dirty_d;
    logic                  err_q, err_d;
    logic                  err_set;
    logic                  addr_ok, data_ok;
`ifdef CFG_READBACK_EN
    logic [SEL_W-1:0]      rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
`endif

    assign chany_out   = chany_in;
    assign cfg_pending = |dirty_q;
    assign cfg_err     = err_q;
`ifdef CFG_READBACK_EN
    assign cfg_rdata   = rdata_q;
    assign cfg_rvalid  = rvalid_q;
`endif

    // Taps beyond MUX_SIZE are tied low so an out-of-range select yields 0.
    logic [SEL_N-1:0] taps_w [NUM_IPIN];
    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
            for (gk = 0; gk < SEL_N; gk++) begin : g_tap
                if (gk < MUX_SIZE) begin : g_real
                    localparam int TRACK = (PIN_OFFSET * gi + TAP_STRIDE * gk) % CHAN_WIDTH;
                    assign taps_w[gi][gk] = chany_in[TRACK];
                end else begin : g_pad
                    assign taps_w[gi][gk] = 1'b0;
                end
            end
            assign grid_pin[gi] = taps_w[gi][active_q[gi]];
        end
    endgenerate

    assign addr_ok = ({1'b0, cfg_addr}  < NUM_IPIN_L);
    assign data_ok = ({1'b0, cfg_wdata} < MUX_SIZE_L);

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        dirty_d   = dirty_q;
        err_set   = 1'b0;
        cfg_ready = (state_q == IDLE) && !cfg_commit;
`ifdef CFG_READBACK_EN
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_commit) begin
                    // Commit outranks any request presented in the same cycle.
                    state_d = COMMIT;
                    for (int i = 0; i < NUM_IPIN; i++) begin
                        if (dirty_q[i]) active_d[i] = shadow_q[i];
                    end
                    dirty_d = '0;
                end else if (cfg_valid && cfg_we) begin
                    if (addr_ok && data_ok) begin
                        shadow_d[cfg_addr] = cfg_wdata;
                        dirty_d[cfg_addr]  = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (cfg_valid) begin
                    state_d = RD_RSP;
                    err_set = !addr_ok;
`ifdef CFG_READBACK_EN
                    rdata_d  = addr_ok ? shadow_q[cfg_addr] : '0;
                    rvalid_d = 1'b1;
`endif
                end
            end
            COMMIT:  state_d = IDLE;
            RD_RSP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        err_d = err_set ? 1'b1 : (cfg_err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_IPIN; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            dirty_q  <= '0;
            err_q    <= 1'b0;
`ifdef CFG_READBACK_EN
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
            err_q    <= err_d;
`ifdef CFG_READBACK_EN
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`endif
        end
    end

endmodule

// File: tb/tb_cb_dbuf_cfg_mux.sv
// Self-checking bench for cb_dbuf_cfg_mux: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the select registers.
module tb_cb_dbuf_cfg_mux;
    localparam int CW = 18, NP = 5, MS = 6, PO = 2, TS = 3, SW = 3, AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] chany_in = '0;
    logic [CW-1:0] chany_out;
    logic [NP-1:0] grid_pin;
    logic          cfg_valid = 0, cfg_we = 0, cfg_commit = 0, cfg_err_clr = 0;
    logic [AW-1:0] cfg_addr = '0;
    logic [SW-1:0] cfg_wdata = '0;
    logic          cfg_ready, cfg_pending, cfg_err;
`ifdef CFG_READBACK_EN
    logic [SW-1:0] cfg_rdata;
    logic          cfg_rvalid;
`endif

    int checks = 0, failures = 0;
    bit cmp_en = 0;

    cb_dbuf_cfg_mux dut (
        .prog_clk(clk), .pReset(rst_n), .chany_in(chany_in), .chany_out(chany_out),
        .grid_pin(grid_pin), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .cfg_err_clr(cfg_err_clr)
`ifdef CFG_READBACK_EN
        , .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: select arrays plus a count of cycles the block stays busy.
    int m_shadow [NP];
    int m_active [NP];
    bit m_dirty  [NP];
    bit m_err;
    int m_busy;
    int m_rdata;
    bit m_rvalid;

    function automatic bit m_ready();
        return (m_busy == 0) && !cfg_commit;
    endfunction

    function automatic logic [NP-1:0] m_grid();
        logic [NP-1:0] g;
        for (int i = 0; i < NP; i++)
            g[i] = (m_active[i] < MS) ? chany_in[(PO * i + TS * m_active[i]) % CW] : 1'b0;
        return g;
    endfunction

    function automatic bit m_pending();
        bit p = 0;
        for (int i = 0; i < NP; i++) p |= m_dirty[i];
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                m_shadow[i] = 0; m_active[i] = 0; m_dirty[i] = 0;
            end
            m_err = 0; m_busy = 0; m_rdata = 0; m_rvalid = 0;
        end else begin
            bit err_set;
            err_set  = 0;
            m_rvalid = 0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (cfg_commit) begin
                for (int i = 0; i < NP; i++) begin
                    if (m_dirty[i]) m_active[i] = m_shadow[i];
                    m_dirty[i] = 0;
                end
                m_busy = 1;
            end else if (cfg_valid && cfg_we) begin
                if (int'(cfg_addr) < NP && int'(cfg_wdata) < MS) begin
                    m_shadow[cfg_addr] = int'(cfg_wdata);
                    m_dirty[cfg_addr]  = 1;
                end else err_set = 1;
            end else if (cfg_valid) begin
                m_busy   = 1;
                m_rvalid = 1;
                if (int'(cfg_addr) < NP) m_rdata = m_shadow[cfg_addr];
                else begin m_rdata = 0; err_set = 1; end
            end
            if (err_set) m_err = 1;
            else if (cfg_err_clr) m_err = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("chany_out", 32'(chany_out), 32'(chany_in));
            chk("grid_pin", 32'(grid_pin), 32'(m_grid()));
            chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
            chk("cfg_pending", 32'(cfg_pending), 32'(m_pending()));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef CFG_READBACK_EN
            chk("cfg_rvalid", 32'(cfg_rvalid), 32'(m_rvalid));
            chk("cfg_rdata", 32'(cfg_rdata), 32'(m_rdata));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cfg_valid = 0; cfg_we = 0; cfg_commit = 0; cfg_err_clr = 0;
    endtask

    task automatic wr(input int addr, input int data);
        cfg_valid = 1; cfg_we = 1; cfg_addr = AW'(addr); cfg_wdata = SW'(data);
        cyc();
        idle();
        $display("txn write pin%0d=%0d err=%0b pending=%0b", addr, data, cfg_err, cfg_pending);
    endtask

    task automatic commit();
        cfg_commit = 1;
        #1 chk("ready_low_on_commit", 32'(cfg_ready), 32'd0);
        cyc();
        idle();
        $display("txn commit");
    endtask

    initial begin
        chany_in = 18'h00001;
        cyc(); cyc();
        rst_n = 1;
        cmp_en = 1;
        #1;
        chk("rst_grid", 32'(grid_pin), 32'h01);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);

        wr(0, 3);
        chk("pin0_before_commit", 32'(grid_pin[0]), 32'd1);
        chk("pending_after_write", 32'(cfg_pending), 32'd1);
        commit();
        chany_in = 18'h00001 << 9;
        #1;
        chk("pin0_track9", 32'(grid_pin[0]), 32'd1);
        chk("pending_after_commit", 32'(cfg_pending), 32'd0);
        chk("ready_in_commit", 32'(cfg_ready), 32'd0);
        cyc();
        chk("ready_after_commit", 32'(cfg_ready), 32'd1);

        wr(1, 5);
        wr(2, 1);
        commit();
        chany_in = 18'h00001 << 17;
        #1 chk("pin1_track17", 32'(grid_pin), 32'h02);
        chany_in = 18'h00001 << 7;
        #1 chk("pin2_track7", 32'(grid_pin), 32'h04);
        cyc();

        wr(7, 0);
        chk("err_bad_addr", 32'(cfg_err), 32'd1);
        chk("no_dirty_bad_addr", 32'(cfg_pending), 32'd0);
        cfg_err_clr = 1; cyc(); idle();
        chk("err_cleared", 32'(cfg_err), 32'd0);
        wr(0, 6);
        chk("err_bad_data", 32'(cfg_err), 32'd1);
        cfg_err_clr = 1; wr(5, 1);
        chk("err_set_wins", 32'(cfg_err), 32'd1);
        cfg_err_clr = 1; cyc(); idle();

        cfg_valid = 1; cfg_we = 1; cfg_addr = 3; cfg_wdata = 4; cfg_commit = 1;
        #1 chk("wr_blocked_by_commit", 32'(cfg_ready), 32'd0);
        cyc(); cfg_commit = 0;
        chk("wr_held_commit_cycle", 32'(cfg_ready), 32'd0);
        cyc();
        chk("wr_held_accepted", 32'(cfg_ready), 32'd1);
        cyc(); idle();
        chk("held_write_pending", 32'(cfg_pending), 32'd1);

        wr(4, 2);
        cfg_valid = 1; cfg_we = 0; cfg_addr = 4;
        cyc(); idle();
        chk("ready_in_rd_rsp", 32'(cfg_ready), 32'd0);
`ifdef CFG_READBACK_EN
        chk("rvalid_rd_rsp", 32'(cfg_rvalid), 32'd1);
        chk("rdata_pin4", 32'(cfg_rdata), 32'd2);
`endif
        cyc();
`ifdef CFG_READBACK_EN
        chk("rvalid_one_cycle", 32'(cfg_rvalid), 32'd0);
        chk("rdata_holds", 32'(cfg_rdata), 32'd2);
`endif
        $display("txn read pin4");
        cfg_valid = 1; cfg_we = 0; cfg_addr = 4;
        cyc(); idle();
        chany_in = 18'h00001;
        rst_n = 0;
        #1;
        chk("rst_mid_rd_grid", 32'(grid_pin), 32'h01);
        chk("rst_mid_rd_pending", 32'(cfg_pending), 32'd0);
`ifdef CFG_READBACK_EN
        chk("rst_mid_rd_rvalid", 32'(cfg_rvalid), 32'd0);
`endif
        cyc();
        rst_n = 1;
        cyc();

        for (int n = 0; n < 3000; n++) begin
            chany_in    = CW'($urandom);
            cfg_valid   = ($urandom_range(0, 1) == 1);
            cfg_we      = ($urandom_range(0, 3) != 0);
            cfg_addr    = AW'($urandom_range(0, 7));
            cfg_wdata   = SW'($urandom_range(0, 7));
            cfg_commit  = ($urandom_range(0, 9) == 0);
            cfg_err_clr = ($urandom_range(0, 9) == 0);
            rst_n       = ($urandom_range(0, 299) != 0);
            cyc();
        end
        idle();
        rst_n = 1;
        cyc();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cb_dbuf_cfg_mux.md
Name: cb_dbuf_cfg_mux

Overview:
- Parametrised vertical connection block for the routing fabric: CHAN_WIDTH tracks, NUM_IPIN grid input pins, each pin driven by a MUX_SIZE-input routing mux.
- Configuration is double-buffered. Writes land in shadow select registers; a commit copies all dirty shadows into the active selects in one cycle, so the fabric is reconfigured atomically.
- Sits between the configuration-protocol controller and the CLB pins. It replaces fixed-size per-pin mux/mem/decoder instances.

Parameters:
- CHAN_WIDTH, 18, number of tracks passing through the block.
- NUM_IPIN, 5, number of grid input pins driven.
- MUX_SIZE, 6, taps per pin mux (must be ≥2).
- PIN_OFFSET, 2, track offset between consecutive pins' tap 0.
- TAP_STRIDE, 3, track distance between consecutive taps of one pin.
- SEL_W, $clog2(MUX_SIZE), derived width of the binary select.
- ADDR_W, max(1,$clog2(NUM_IPIN)), derived width of the config address.

Ports:
- prog_clk  in  1  single clock (config and state).
- pReset  in  1  asynchronous, active-low reset.
- chany_in  in  CHAN_WIDTH  incoming tracks.
- chany_out  out  CHAN_WIDTH  outgoing tracks.
- grid_pin  out  NUM_IPIN  mux outputs to the CLB.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  block can accept a request.
- cfg_we  in  1  1 = write, 0 = read.
- cfg_addr  in  ADDR_W  pin index.
- cfg_wdata  in  SEL_W  select value to write.
- cfg_commit  in  1  single-cycle pulse; copy shadow to active.
- cfg_pending  out  1  OR of the dirty bits.
- cfg_err  out  1  sticky error flag.
- cfg_err_clr  in  1  clears cfg_err.
- cfg_rdata  out  SEL_W  read data (only with CFG_READBACK_EN).
- cfg_rvalid  out  1  read data valid (only with CFG_READBACK_EN).

Behaviour:
- chany_out = chany_in, purely combinational, no register.
- Tap k of pin i is track (PIN_OFFSET*i + TAP_STRIDE*k) mod CHAN_WIDTH.
- grid_pin[i] = chany_in[tap(i, active_sel[i])], combinational from the active register. If active_sel[i] ≥ MUX_SIZE, grid_pin[i] = 0.
- FSM states: IDLE, COMMIT, RD_RSP.
  - cfg_ready = (state==IDLE) && !cfg_commit. Commit has priority over a request in the same cycle; that request is not accepted and must be held.
  - IDLE + cfg_commit → COMMIT. For every i with dirty[i]=1, active_sel[i] ← shadow_sel[i] on the next edge. All dirty bits clear on that edge. Return to IDLE after 1 cycle.
  - cfg_commit with no dirty bits still takes the COMMIT cycle; active is unchanged.
  - A cfg_commit pulse arriving outside IDLE is ignored.
  - Accepted write (cfg_valid & cfg_ready & cfg_we), address < NUM_IPIN and data < MUX_SIZE: shadow_sel[addr] ← wdata, dirty[addr] ← 1. Stay in IDLE; back-to-back writes sustain 1 per cycle.
  - Write to addr ≥ NUM_IPIN or with data ≥ MUX_SIZE: no register change; cfg_err ← 1.
  - Accepted read: go to RD_RSP for 1 cycle, then IDLE. A read uses 2 cycles of ready.
- cfg_err: set on an erroring write or an out-of-range read. Clear on cfg_err_clr, but set wins if both occur in the same cycle.
- cfg_pending = |dirty; it is registered state, not a pulse.
- Reset (async assert, synchronous release edge not required):
  - state = IDLE; shadow_sel = 0 and active_sel = 0 for all pins; dirty = 0.
  - cfg_err = 0, cfg_rdata = 0, cfg_rvalid = 0.
  - grid_pin[i] therefore follows tap 0 of each pin immediately.
- Reset during COMMIT or RD_RSP aborts the operation; all state returns to reset values.

Optional Feature:
- CFG_READBACK_EN defined:
  - In RD_RSP, cfg_rvalid = 1 for exactly 1 cycle and cfg_rdata = shadow_sel[addr] as captured at accept.
  - Out-of-range read returns cfg_rdata = 0 and sets cfg_err.
  - cfg_rdata holds its value until the next read.
- CFG_READBACK_EN not defined:
  - cfg_rdata and cfg_rvalid ports are absent.
  - Reads complete through RD_RSP with no data returned; out-of-range reads still set cfg_err.

Test Plan:
- After reset, drive chany_in = 18'h00001 → grid_pin[0] = 1; pins 1..4 = 0; cfg_pending = 0; cfg_ready = 1.
- Write pin0 = 3 → grid_pin[0] still follows track 0 and cfg_pending = 1. Then pulse cfg_commit → one cycle later grid_pin[0] follows track 9, cfg_pending = 0, and cfg_ready is 0 for exactly one cycle.
- Writes pin1 = 5 and pin2 = 1 on consecutive cycles, then commit → both update on the same edge. Pin1 follows track 17 ((2+15) mod 18); pin2 follows track 7.
- Write pin7 = 0, then write pin0 = 6 → cfg_err = 1 and no shadow or dirty change. cfg_err_clr → 0. Simultaneous bad write and cfg_err_clr → cfg_err stays 1.
- cfg_valid write and cfg_commit in the same cycle → write not accepted (ready = 0). Write accepted 2 cycles later if still held; it stays pending until the next commit.
- With CFG_READBACK_EN: write pin4 = 2, then read pin4 → cfg_rvalid high for 1 cycle with cfg_rdata = 2. Assert pReset mid-RD_RSP → cfg_rvalid = 0 and all selects = 0.
